cpu_bus_ctrl: RTL and testbench
===============================

// Module: cpu_bus_ctrl
// PURPOSE
//  Memory-bus controller directly downstream of the PicoRV32 core wrapper.
//  Consumes the core's valid/ready memory port and decodes each access to on-chip RAM
//  (stack/data), program ROM (reset vector at 0x20000) or the IO peripheral bus.
//  Generates the ready handshake and returns read data.
//  Unmapped accesses, ROM writes and IO/ROM timeouts complete with rdata=0 and a bus_err pulse.
// PARAMETERS
//  RAM_BASE  32'h0000_0000  byte base of RAM; RAM spans RAM_BASE .. RAM_BASE+4*2^RAM_AW-1
//  RAM_AW    14             RAM word-address width (64 KiB; stack top 0x10000)
//  ROM_BASE  32'h0002_0000  byte base of program ROM
//  ROM_AW    14             ROM word-address width
//  IO_BASE   32'h0003_0000  byte base of IO window
//  IO_AW     8              IO word-address width
//  TIMEOUT   255            max wait cycles for rom_rdy/io_rdy, 1..255
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous reset, active-high
//  cpu_mem_op   in   1       CPU request valid; held high until cpu_mem_rdy
//  cpu_adr      in   32      CPU byte address (bits [1:0] ignored)
//  cpu_do       in   32      CPU write data
//  cpu_wren     in   4       byte write strobes; 0 = read
//  cpu_mem_rdy  out  1       one-cycle completion pulse
//  cpu_di       out  32      read data, valid while cpu_mem_rdy=1
//  ram_en       out  1       RAM access strobe (1 cycle)
//  ram_adr      out  RAM_AW  RAM word address
//  ram_do       out  32      RAM write data
//  ram_we       out  4       RAM byte write enables
//  ram_di       in   32      RAM read data, valid 1 cycle after ram_en
//  rom_req      out  1       ROM read request, held until rom_rdy or timeout
//  rom_adr      out  ROM_AW  ROM word address
//  rom_rdy      in   1       ROM data valid
//  rom_di       in   32      ROM read data
//  io_req       out  1       IO request, held until io_rdy or timeout
//  io_adr       out  IO_AW   IO word address
//  io_do        out  32      IO write data
//  io_wren      out  4       IO byte strobes
//  io_rdy       in   1       IO access complete
//  io_di        in   32      IO read data
//  bus_err      out  1       one-cycle error pulse, coincident with the erroring cpu_mem_rdy
// BEHAVIOUR
//  - Reset: state=IDLE; cpu_mem_rdy, cpu_di, ram_en, ram_we, rom_req, io_req, io_wren, bus_err = 0.
//    Reset mid-access aborts it: no cpu_mem_rdy, all requests drop on the next edge.
//  - All outputs are registered. States: IDLE, RAM_ACC, RAM_CAP, EXT_WAIT, DONE.
//  - IDLE: cpu_mem_op=1 sampled at edge N latches address, data and strobes, then decodes:
//    RAM hit -> RAM_ACC. ram_en=1 in cycle N+1; ram_we=cpu_wren.
//      Write: cpu_mem_rdy=1 at N+2 via DONE.
//      Read: RAM_CAP captures ram_di at N+2; cpu_mem_rdy=1 and cpu_di valid at N+3.
//    ROM hit, read -> EXT_WAIT with rom_req=1 from N+1.
//    ROM hit, write -> DONE; write dropped, bus_err=1.
//    IO hit -> EXT_WAIT with io_req=1 from N+1; io_wren=cpu_wren.
//    No hit -> DONE at N+1 with cpu_di=0, bus_err=1.
//  - EXT_WAIT: 8-bit wait counter cleared on entry, +1 per cycle.
//    rdy sampled 1: capture data (0 for writes), drop req, go DONE; cpu_mem_rdy asserts next cycle.
//    Counter reaches TIMEOUT with rdy=0: drop req, cpu_di=0, bus_err=1, go DONE.
//  - DONE: cpu_mem_rdy=1 for exactly one cycle, then IDLE. cpu_mem_op seen during DONE is ignored.
//    The next request is accepted in IDLE at the earliest.
//  - Address compares use full 32 bits: hit iff base <= adr < base + 4*2^AW.
//    Word address = (adr - base) >> 2. Regions must not overlap.
//  - cpu_di holds its last value outside cpu_mem_rdy; cpu_wren=0 never drives ram_we/io_wren.
// TESTING
//  1. Read 0x0000_0004, RAM returns 0x1234_5678 -> ram_en at N+1, cpu_mem_rdy+cpu_di=0x1234_5678 at N+3.
//  2. Write 0x0000_FFFC, data 0xAABB_CCDD, wren 4'b0011 -> ram_we=0011, ram_adr=0x3FFF at N+1, rdy at N+2, no bus_err.
//  3. Read 0x0002_0000, rom_rdy after 5 cycles, data 0x0000_0013 -> rom_adr=0, rdy with 0x13, no bus_err.
//  4. IO write 0x0003_0010, io_rdy never rises -> io_req high 255 cycles, then rdy+bus_err, cpu_di=0.
//  5. Read 0x0001_0000 (unmapped), then write to 0x0002_0008 -> each rdy+bus_err, ram_en/rom_req stay 0.
//  6. reset=1 during EXT_WAIT of IO read -> io_req=0 next cycle, no rdy; next RAM read completes normally.

Source files
------------

// File: rtl/cpu_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_ctrl_if
//  Description : Signal bundle between the PicoRV32 memory port, the bus
//                controller and its three downstream targets (RAM, ROM, IO).
//                modport slave  - the controller's view (cpu_bus_ctrl)
//                modport master - the environment's view (core + memories)
//  Ports       : CPU request/response, RAM strobe/address/data, ROM
//                request/ready, IO request/ready, bus_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_bus_ctrl_if #(
    parameter int RAM_AW = 14,
    parameter int ROM_AW = 14,
    parameter int IO_AW  = 8
);
    // CPU side
    logic              cpu_mem_op;
    logic [31:0]       cpu_adr;
    logic [31:0]       cpu_do;
    logic [3:0]        cpu_wren;
    logic              cpu_mem_rdy;
    logic [31:0]       cpu_di;
    // RAM
    logic              ram_en;
    logic [RAM_AW-1:0] ram_adr;
    logic [31:0]       ram_do;
    logic [3:0]        ram_we;
    logic [31:0]       ram_di;
    // ROM
    logic              rom_req;
    logic [ROM_AW-1:0] rom_adr;
    logic              rom_rdy;
    logic [31:0]       rom_di;
    // IO
    logic              io_req;
    logic [IO_AW-1:0]  io_adr;
    logic [31:0]       io_do;
    logic [3:0]        io_wren;
    logic              io_rdy;
    logic [31:0]       io_di;
    // Error
    logic              bus_err;

    modport slave (
        input  cpu_mem_op, cpu_adr, cpu_do, cpu_wren,
        input  ram_di, rom_rdy, rom_di, io_rdy, io_di,
        output cpu_mem_rdy, cpu_di,
        output ram_en, ram_adr, ram_do, ram_we,
        output rom_req, rom_adr,
        output io_req, io_adr, io_do, io_wren,
        output bus_err
    );

    modport master (
        output cpu_mem_op, cpu_adr, cpu_do, cpu_wren,
        output ram_di, rom_rdy, rom_di, io_rdy, io_di,
        input  cpu_mem_rdy, cpu_di,
        input  ram_en, ram_adr, ram_do, ram_we,
        input  rom_req, rom_adr,
        input  io_req, io_adr, io_do, io_wren,
        input  bus_err
    );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_ctrl
//  Description : Memory-bus controller behind the PicoRV32 wrapper. Decodes
//                each CPU access to RAM, program ROM or the IO window,
//                sequences the target handshake and returns read data with a
//                one-cycle cpu_mem_rdy pulse. Unmapped accesses, ROM writes
//                and ROM/IO timeouts complete with cpu_di=0 and bus_err=1.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                bus   - cpu_bus_ctrl_if.slave (CPU, RAM, ROM, IO, bus_err)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_ctrl #(
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter int          RAM_AW   = 14,
    parameter logic [31:0] ROM_BASE = 32'h0002_0000,
    parameter int          ROM_AW   = 14,
    parameter logic [31:0] IO_BASE  = 32'h0003_0000,
    parameter int          IO_AW    = 8,
    parameter int          TIMEOUT  = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cpu_bus_ctrl_if.slave      bus
);

    // Byte span of each region
    localparam logic [31:0] c_ram_span = 32'd4 << RAM_AW;
    localparam logic [31:0] c_rom_span = 32'd4 << ROM_AW;
    localparam logic [31:0] c_io_span  = 32'd4 << IO_AW;
    localparam logic [7:0]  c_timeout  = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RAM_ACC  = 3'd1,
        S_RAM_CAP  = 3'd2,
        S_EXT_WAIT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_is_io;
    logic        r_is_write;

    // Offset from each base. Unsigned wrap makes a single compare sufficient:
    // an address below the base wraps to a huge offset and fails "< span".
    logic [31:0] w_ram_off;
    logic [31:0] w_rom_off;
    logic [31:0] w_io_off;
    logic        w_ram_hit;
    logic        w_rom_hit;
    logic        w_io_hit;
    logic        w_is_write;
    logic        w_ext_rdy;
    logic [31:0] w_ext_di;

    assign w_ram_off  = bus.cpu_adr - RAM_BASE;
    assign w_rom_off  = bus.cpu_adr - ROM_BASE;
    assign w_io_off   = bus.cpu_adr - IO_BASE;
    assign w_ram_hit  = (w_ram_off < c_ram_span);
    assign w_rom_hit  = (w_rom_off < c_rom_span);
    assign w_io_hit   = (w_io_off  < c_io_span);
    assign w_is_write = |bus.cpu_wren;

    // External target currently being waited on
    assign w_ext_rdy  = r_is_io ? bus.io_rdy : bus.rom_rdy;
    assign w_ext_di   = r_is_io ? bus.io_di  : bus.rom_di;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= 8'd0;
            r_is_io         <= 1'b0;
            r_is_write      <= 1'b0;
            bus.cpu_mem_rdy <= 1'b0;
            bus.cpu_di      <= 32'd0;
            bus.ram_en      <= 1'b0;
            bus.ram_adr     <= '0;
            bus.ram_do      <= 32'd0;
            bus.ram_we      <= 4'd0;
            bus.rom_req     <= 1'b0;
            bus.rom_adr     <= '0;
            bus.io_req      <= 1'b0;
            bus.io_adr      <= '0;
            bus.io_do       <= 32'd0;
            bus.io_wren     <= 4'd0;
            bus.bus_err     <= 1'b0;
        end else begin
            // Single-cycle pulses default low
            bus.cpu_mem_rdy <= 1'b0;
            bus.bus_err     <= 1'b0;
            bus.ram_en      <= 1'b0;
            bus.ram_we      <= 4'd0;

            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_mem_op) begin
                        r_is_write <= w_is_write;
                        r_wait_cnt <= 8'd0;
                        if (w_ram_hit) begin
                            bus.ram_en  <= 1'b1;
                            bus.ram_we  <= bus.cpu_wren;
                            bus.ram_adr <= w_ram_off[RAM_AW+1:2];
                            bus.ram_do  <= bus.cpu_do;
                            r_state     <= S_RAM_ACC;
                        end else if (w_rom_hit && !w_is_write) begin
                            bus.rom_req <= 1'b1;
                            bus.rom_adr <= w_rom_off[ROM_AW+1:2];
                            r_is_io     <= 1'b0;
                            r_state     <= S_EXT_WAIT;
                        end else if (w_io_hit) begin
                            bus.io_req  <= 1'b1;
                            bus.io_adr  <= w_io_off[IO_AW+1:2];
                            bus.io_do   <= bus.cpu_do;
                            bus.io_wren <= bus.cpu_wren;
                            r_is_io     <= 1'b1;
                            r_state     <= S_EXT_WAIT;
                        end else begin
                            // Unmapped or ROM write: complete immediately with error
                            bus.cpu_di      <= 32'd0;
                            bus.cpu_mem_rdy <= 1'b1;
                            bus.bus_err     <= 1'b1;
                            r_state         <= S_DONE;
                        end
                    end
                end

                S_RAM_ACC: begin
                    if (r_is_write) begin
                        bus.cpu_mem_rdy <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_state <= S_RAM_CAP;
                    end
                end

                S_RAM_CAP: begin
                    bus.cpu_di      <= bus.ram_di;
                    bus.cpu_mem_rdy <= 1'b1;
                    r_state         <= S_DONE;
                end

                S_EXT_WAIT: begin
                    if (w_ext_rdy) begin
                        bus.cpu_di      <= r_is_write ? 32'd0 : w_ext_di;
                        bus.rom_req     <= 1'b0;
                        bus.io_req      <= 1'b0;
                        bus.io_wren     <= 4'd0;
                        bus.cpu_mem_rdy <= 1'b1;
                        r_state         <= S_DONE;
                    end else if (r_wait_cnt + 8'd1 == c_timeout) begin
                        bus.cpu_di      <= 32'd0;
                        bus.rom_req     <= 1'b0;
                        bus.io_req      <= 1'b0;
                        bus.io_wren     <= 4'd0;
                        bus.cpu_mem_rdy <= 1'b1;
                        bus.bus_err     <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                // cpu_mem_rdy is high for this one cycle; any request still
                // asserted now belongs to the access just finished.
                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_bus_ctrl
//  Description : Self-checking bench for cpu_bus_ctrl. A vector table drives
//                accesses to every region and boundary; a scoreboard queue
//                holds the expected completion of each access and is checked
//                when cpu_mem_rdy pulses. Timeout and reset-abort sequences
//                are written out by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_bus_ctrl_if #(.RAM_AW(14), .ROM_AW(14), .IO_AW(8)) bus ();

    cpu_bus_ctrl #(
        .RAM_BASE(32'h0000_0000), .RAM_AW(14),
        .ROM_BASE(32'h0002_0000), .ROM_AW(14),
        .IO_BASE (32'h0003_0000), .IO_AW (8),
        .TIMEOUT (255)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  wren;
        int          lat;       // target response delay (ROM/IO)
        logic [31:0] ext_data;  // ROM/IO read data
        int          region;    // 0 none, 1 RAM, 2 ROM, 3 IO
        logic [31:0] exp_wadr;
        logic [3:0]  exp_we;
        logic [31:0] exp_di;
        logic        chk_di;
        logic        exp_err;
        int          exp_lat;   // cycles from request to observed rdy
    } vec_t;

    typedef struct {
        logic [31:0] di;
        logic        chk_di;
        logic        err;
        int          lat;
        int          c0;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rdy_cnt  = 0;

    // Target-model state
    logic [31:0] mem [0:16383];
    logic        ram_pend = 1'b0;
    logic [13:0] ram_pend_adr;
    int          ram_en_cnt, rom_seen, io_seen, io_req_cycles;
    logic [31:0] last_ram_adr, last_rom_adr, last_io_adr;
    logic [3:0]  last_ram_we, last_io_wren;
    int          rom_lat = 1, io_lat = 1, rom_cnt = 0, io_cnt = 0;
    logic [31:0] rom_data = 32'd0, io_data = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // RAM: write bytes on ram_en, read data valid the following cycle only
    always @(posedge clk) begin
        #1;
        if (ram_pend) begin
            bus.ram_di = mem[ram_pend_adr];
            ram_pend   = 1'b0;
        end else begin
            bus.ram_di = 32'hBAD0_BAD0;
        end
        if (bus.ram_en) begin
            ram_en_cnt++;
            last_ram_adr = 32'(bus.ram_adr);
            last_ram_we  = bus.ram_we;
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) mem[bus.ram_adr][b*8 +: 8] = bus.ram_do[b*8 +: 8];
            ram_pend     = 1'b1;
            ram_pend_adr = bus.ram_adr;
        end
    end

    // ROM: rdy for one cycle after rom_lat cycles of rom_req
    always @(posedge clk) begin
        #1;
        if (bus.rom_req && !bus.rom_rdy) begin
            rom_seen     = 1;
            last_rom_adr = 32'(bus.rom_adr);
            rom_cnt++;
            if (rom_cnt >= rom_lat) begin
                bus.rom_rdy = 1'b1;
                bus.rom_di  = rom_data;
            end
        end else begin
            bus.rom_rdy = 1'b0;
            bus.rom_di  = 32'hEEEE_EEEE;
            rom_cnt     = 0;
        end
    end

    // IO: same protocol as ROM, also counts io_req high cycles
    always @(posedge clk) begin
        #1;
        if (bus.io_req) io_req_cycles++;
        if (bus.io_req && !bus.io_rdy) begin
            io_seen      = 1;
            last_io_adr  = 32'(bus.io_adr);
            last_io_wren = bus.io_wren;
            io_cnt++;
            if (io_cnt >= io_lat) begin
                bus.io_rdy = 1'b1;
                bus.io_di  = io_data;
            end
        end else begin
            bus.io_rdy = 1'b0;
            bus.io_di  = 32'hEEEE_EEEE;
            io_cnt     = 0;
        end
    end

    // Completion monitor / scoreboard checker
    always @(posedge clk) begin : p_mon
        exp_t e;
        #1;
        if (bus.bus_err && !bus.cpu_mem_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_err_alone: bus_err=1 with cpu_mem_rdy=0 at cycle %0d, required 0", cyc);
        end
        if (bus.cpu_mem_rdy === 1'b1) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdy: cpu_mem_rdy=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                chk("bus_err", 32'(bus.bus_err), 32'(e.err));
                if (e.chk_di) chk("cpu_di", bus.cpu_di, e.di);
                if (e.lat != 0) chk("rdy_latency", 32'(cyc - e.c0), 32'(e.lat));
            end
        end
    end

    task automatic run_access(input int id, input vec_t v);
        int   r0;
        exp_t e;
        rom_lat = v.lat; rom_data = v.ext_data;
        io_lat  = v.lat; io_data  = v.ext_data;
        ram_en_cnt = 0; rom_seen = 0; io_seen = 0; io_req_cycles = 0;
        @(negedge clk);
        e.di = v.exp_di; e.chk_di = v.chk_di; e.err = v.exp_err;
        e.lat = v.exp_lat; e.c0 = cyc;
        sb.push_back(e);
        r0 = rdy_cnt;
        bus.cpu_mem_op = 1'b1;
        bus.cpu_adr    = v.adr;
        bus.cpu_do     = v.data;
        bus.cpu_wren   = v.wren;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdy_cnt != r0) break;
        end
        if (rdy_cnt == r0) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d rdy_timeout: no cpu_mem_rdy within 400 cycles, required one", id);
            void'(sb.pop_back());
        end
        // Request stays high across the DONE edge; it must be ignored there.
        @(negedge clk);
        bus.cpu_mem_op = 1'b0;
        bus.cpu_wren   = 4'd0;
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d regions", id),
            {16'd0, 8'(ram_en_cnt), 7'd0, rom_seen[0], 7'd0, io_seen[0]},
            {16'd0, 8'(v.region == 1), 7'd0, (v.region == 2), 7'd0, (v.region == 3)});
        case (v.region)
            1: begin
                chk($sformatf("v%0d ram_adr", id), last_ram_adr, v.exp_wadr);
                chk($sformatf("v%0d ram_we", id), 32'(last_ram_we), 32'(v.exp_we));
            end
            2: chk($sformatf("v%0d rom_adr", id), last_rom_adr, v.exp_wadr);
            3: begin
                chk($sformatf("v%0d io_adr", id), last_io_adr, v.exp_wadr);
                chk($sformatf("v%0d io_wren", id), 32'(last_io_wren), 32'(v.exp_we));
            end
            default: ;
        endcase
    endtask

    vec_t vecs [14];
    vec_t hv;
    int   r_before;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        mem[0]      = 32'hA5A5_A5A5;
        mem[1]      = 32'h1234_5678;
        mem[14'h3FFF] = 32'h1122_3344;

        //            adr            data           wren  lat ext_data       rg wadr    we    exp_di         chk err lat
        vecs[0]  = '{32'h0000_0004, 32'h0,         4'h0, 0, 32'h0,          1, 32'h1,    4'h0, 32'h1234_5678, 1, 0, 3};
        vecs[1]  = '{32'h0000_FFFC, 32'hAABB_CCDD, 4'h3, 0, 32'h0,          1, 32'h3FFF, 4'h3, 32'h0,         0, 0, 2};
        vecs[2]  = '{32'h0000_FFFC, 32'h0,         4'h0, 0, 32'h0,          1, 32'h3FFF, 4'h0, 32'h1122_CCDD, 1, 0, 3};
        vecs[3]  = '{32'h0000_0000, 32'h0,         4'h0, 0, 32'h0,          1, 32'h0,    4'h0, 32'hA5A5_A5A5, 1, 0, 3};
        vecs[4]  = '{32'h0002_0000, 32'h0,         4'h0, 5, 32'h0000_0013,  2, 32'h0,    4'h0, 32'h0000_0013, 1, 0, 6};
        vecs[5]  = '{32'h0002_FFFC, 32'h0,         4'h0, 1, 32'hDEAD_BEEF,  2, 32'h3FFF, 4'h0, 32'hDEAD_BEEF, 1, 0, 2};
        vecs[6]  = '{32'h0003_0004, 32'h0,         4'h0, 3, 32'hCAFE_F00D,  3, 32'h1,    4'h0, 32'hCAFE_F00D, 1, 0, 4};
        vecs[7]  = '{32'h0003_0010, 32'h0000_0055, 4'hF, 2, 32'h9999_9999,  3, 32'h4,    4'hF, 32'h0,         1, 0, 3};
        vecs[8]  = '{32'h0001_0000, 32'h0,         4'h0, 0, 32'h0,          0, 32'h0,    4'h0, 32'h0,         1, 1, 1};
        vecs[9]  = '{32'h0002_0008, 32'h1111_1111, 4'hF, 0, 32'h0,          0, 32'h0,    4'h0, 32'h0,         1, 1, 1};
        vecs[10] = '{32'h0003_0400, 32'h0,         4'h0, 0, 32'h0,          0, 32'h0,    4'h0, 32'h0,         1, 1, 1};
        vecs[11] = '{32'h0003_03FC, 32'h0,         4'h0, 2, 32'h0BAD_CAFE,  3, 32'hFF,   4'h0, 32'h0BAD_CAFE, 1, 0, 3};
        vecs[12] = '{32'hFFFF_FFFC, 32'h0,         4'h0, 0, 32'h0,          0, 32'h0,    4'h0, 32'h0,         1, 1, 1};
        vecs[13] = '{32'h0001_FFFC, 32'h0,         4'h0, 0, 32'h0,          0, 32'h0,    4'h0, 32'h0,         1, 1, 1};

        reset          = 1'b1;
        bus.cpu_mem_op = 1'b0;
        bus.cpu_adr    = 32'd0;
        bus.cpu_do     = 32'd0;
        bus.cpu_wren   = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.cpu_mem_rdy, bus.ram_en, bus.rom_req, bus.io_req, bus.bus_err,
             bus.ram_we, bus.io_wren, 19'd0},
            32'd0);
        chk("reset_cpu_di", bus.cpu_di, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_access(i, vecs[i]);

        // IO write that is never acknowledged: full timeout
        hv = '{32'h0003_0010, 32'h0000_0001, 4'hF, 100000, 32'h0, 3, 32'h4, 4'hF, 32'h0, 1, 1, 256};
        run_access(100, hv);
        chk("timeout io_req_cycles", 32'(io_req_cycles), 32'd255);

        // Reset in the middle of an IO read wait: aborted silently
        io_lat = 100000;
        @(negedge clk);
        r_before       = rdy_cnt;
        bus.cpu_mem_op = 1'b1;
        bus.cpu_adr    = 32'h0003_0008;
        bus.cpu_wren   = 4'd0;
        repeat (10) @(negedge clk);
        chk("abort io_req_before_reset", 32'(bus.io_req), 32'd1);
        reset          = 1'b1;
        bus.cpu_mem_op = 1'b0;
        @(posedge clk);
        #1;
        chk("abort io_req_dropped", 32'(bus.io_req), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort no_rdy", 32'(rdy_cnt - r_before), 32'd0);
        run_access(200, vecs[0]);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
